dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data_memory (32-bit word, 20-bit address, byte enable) between the pipeline MEM stage (CPU)
//  and a DMA/image loader master. CPU has priority; DMA gets bounded-latency access via starvation counter and burst cap.
//  Drives CPU stall when the MEM stage must wait; sits between the MEM stage, the DMA engine and data_memory.
// PARAMETERS
//  ADDR_W     20  memory address width
//  DATA_W     32  memory data width
//  MAX_WAIT    8  cycles a pending DMA request may be denied before it preempts CPU (>=1)
//  MAX_BURST  16  max DMA beats per ownership while CPU is requesting (>=1)
// PORTS
//  clk        in   1       clock
//  rst        in   1       async reset, active-low
//  cpu_req    in   1       MEM stage access request (MemRead|MemWrite)
//  cpu_we     in   1       1=write 0=read
//  cpu_be     in   1       byte enable, passed to mem_be
//  cpu_addr   in   ADDR_W  address
//  cpu_wdata  in   DATA_W  write data
//  cpu_stall  out  1       cpu_req & ~cpu granted (combinational)
//  cpu_rvalid out  1       read data valid for CPU (1 cycle after granted read)
//  cpu_rdata  out  DATA_W  = mem_rdata
//  dma_req    in   1       DMA beat request
//  dma_we     in   1       1=write 0=read
//  dma_last   in   1       final beat of burst
//  dma_addr   in   ADDR_W  address
//  dma_wdata  in   DATA_W  write data
//  dma_gnt    out  1       beat accepted this cycle (combinational)
//  dma_rvalid out  1       read data valid for DMA
//  dma_rdata  out  DATA_W  = mem_rdata
//  mem_addr/mem_wdata/mem_be/mem_we/mem_re  out  ADDR_W/DATA_W/1/1/1  to data_memory, muxed from granted master
//  mem_rdata  in   DATA_W  synchronous read data (1-cycle latency)
// BEHAVIOUR
//  - FSM states IDLE, CPU_OWN, DMA_OWN (registered owner); grant is combinational from state + requests.
//  - IDLE/CPU_OWN: DMA granted if dma_req & (~cpu_req | wait_cnt==MAX_WAIT); else CPU granted if cpu_req.
//    Next state: DMA_OWN if DMA granted, CPU_OWN if CPU granted, else IDLE.
//  - DMA_OWN: DMA granted while dma_req & ~(cpu_req & burst_cnt==MAX_BURST); else CPU granted if cpu_req.
//    Leave to IDLE (or CPU_OWN if CPU granted) on: granted beat with dma_last, dma_req low, or burst cap hit.
//  - wait_cnt: +1 each cycle dma_req & ~dma_gnt, saturates at MAX_WAIT, clears on dma_gnt or ~dma_req.
//  - burst_cnt: +1 per DMA beat in DMA_OWN, clears on leaving DMA_OWN; counts only while cpu_req matters for cap.
//  - Exactly one master granted per cycle; mem_we = gnt & we, mem_re = gnt & ~we; no grant -> we=re=0, addr/wdata=0.
//  - Read latency 1: rvalid for the master granted a read in cycle N asserts in N+1 only, for one cycle.
//  - Writes complete in grant cycle; no rvalid.
//  - Simultaneous dma_last with burst cap: single exit to IDLE/CPU_OWN, counters cleared.
//  - Reset (async, any time incl. mid-burst): state IDLE, wait_cnt=burst_cnt=0, cpu_rvalid=dma_rvalid=0;
//    while rst low cpu_stall, dma_gnt, mem_we, mem_re forced 0. DMA must reissue the interrupted burst.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs cpu_stall_cycles[15:0], dma_beats[15:0]; saturating counters of
//   cycles with cpu_stall=1 and of dma_gnt beats; cleared by reset. Undefined: ports and counters absent,
//   arbitration identical.
// TESTING
//  1 CPU only: read addr 0x00010 -> mem_re=1 same cycle, cpu_rvalid=1 next cycle, cpu_stall=0 always.
//  2 CPU+DMA req together, CPU holds req -> CPU granted 8 cycles, cycle 9 dma_gnt=1, cpu_stall=1 that cycle.
//  3 DMA 20-beat burst, CPU req from beat 3 -> DMA granted exactly 16 beats, then CPU granted, cpu_stall=0.
//  4 DMA 4-beat write burst, dma_last on beat 4, no CPU -> 4 mem_we pulses, state IDLE next, wait/burst=0.
//  5 Reset asserted mid DMA burst (beat 5) -> same-instant dma_gnt=0, mem_we=0; after release IDLE, rvalids 0.
//  6 STATS_EN: scenario 2 -> cpu_stall_cycles=1, dma_beats=1; 0xFFFF saturates, no wrap.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA engine, data_memory and dmem_arbiter.
// The arbiter uses the slave modport; the surrounding system uses the master modport.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic              cpu_be;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic              dma_last;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_be;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_last, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_addr, mem_wdata, mem_be, mem_we, mem_re,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_last, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_addr, mem_wdata, mem_be, mem_we, mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU priority, DMA protected by a starvation counter and a burst cap.
// Define DMEM_ARB_STATS_EN to add saturating cpu_stall_cycles / dma_beats counters.
module dmem_arbiter #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int MAX_WAIT  = 8,
   parameter int MAX_BURST = 16
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]    cpu_stall_cycles,
   output logic [15:0]    dma_beats
`endif
);
   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int BURST_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_OWN = 2'd1,
      DMA_OWN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic               cpu_rvalid_q, cpu_rvalid_d;
   logic               dma_rvalid_q, dma_rvalid_d;
   logic               cpu_gnt, dma_gnt;
   logic               wait_max, burst_cap;

   assign wait_max  = (wait_q == WAIT_W'(MAX_WAIT));
   assign burst_cap = bus.cpu_req && (burst_q == BURST_W'(MAX_BURST));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         burst_q      <= '0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         burst_q      <= burst_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      burst_d = '0;
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      case (state_q)
         DMA_OWN: begin
            dma_gnt = bus.dma_req && !burst_cap;
            cpu_gnt = !dma_gnt && bus.cpu_req;
            if (dma_gnt && !bus.dma_last) begin
               state_d = DMA_OWN;
               burst_d = (burst_q == BURST_W'(MAX_BURST)) ? burst_q : burst_q + 1'b1;
            end else begin
               state_d = cpu_gnt ? CPU_OWN : IDLE;
            end
         end
         default: begin
            dma_gnt = bus.dma_req && (!bus.cpu_req || wait_max);
            cpu_gnt = !dma_gnt && bus.cpu_req;
            if (dma_gnt) begin
               // The beat that takes ownership is the first beat of the burst.
               state_d = DMA_OWN;
               burst_d = BURST_W'(1);
            end else if (cpu_gnt) begin
               state_d = CPU_OWN;
            end else begin
               state_d = IDLE;
            end
         end
      endcase

      // Grants must drop the instant reset asserts, not at the next edge.
      if (!rst) begin
         cpu_gnt = 1'b0;
         dma_gnt = 1'b0;
      end

      if (!bus.dma_req || dma_gnt) begin
         wait_d = '0;
      end else if (wait_max) begin
         wait_d = wait_q;
      end else begin
         wait_d = wait_q + 1'b1;
      end

      cpu_rvalid_d = cpu_gnt && !bus.cpu_we;
      dma_rvalid_d = dma_gnt && !bus.dma_we;
   end

   assign bus.cpu_stall  = rst && bus.cpu_req && !cpu_gnt;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.dma_rvalid = dma_rvalid_q;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dma_rdata  = bus.mem_rdata;

   assign bus.mem_we    = (cpu_gnt && bus.cpu_we) || (dma_gnt && bus.dma_we);
   assign bus.mem_re    = (cpu_gnt && !bus.cpu_we) || (dma_gnt && !bus.dma_we);
   assign bus.mem_be    = cpu_gnt ? bus.cpu_be : dma_gnt;
   assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr  : (dma_gnt ? bus.dma_addr  : '0);
   assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : (dma_gnt ? bus.dma_wdata : '0);

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      if (bus.cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (dma_gnt && beat_cnt_q != 16'hFFFF)        beat_cnt_d  = beat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign cpu_stall_cycles = stall_cnt_q;
   assign dma_beats        = beat_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expected bus activity, a monitor checks it.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   localparam int AW = 20;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cpu_stall_cycles;
   logic [15:0] dma_beats;
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8), .MAX_BURST(16)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cpu_stall_cycles(cpu_stall_cycles), .dma_beats(dma_beats));
`else
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8), .MAX_BURST(16)) dut (
      .clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {
      int              m;      // 0 none, 1 cpu, 2 dma
      logic            we;
      logic            be;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      logic            stall;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return {12'h5A5, a};
   endfunction

   // Memory model: synchronous read, one-cycle latency.
   initial bus.mem_rdata = '0;
   always @(posedge clk) begin
      if (bus.mem_re) bus.mem_rdata <= memf(bus.mem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected entry per driven cycle, read data checked one cycle later.
   exp_t prev;
   bit   prev_valid = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
         chk("dma_gnt",   32'(bus.dma_gnt),   32'(e.m == 2));
         chk("mem_we",    32'(bus.mem_we),    32'(e.m != 0 && e.we));
         chk("mem_re",    32'(bus.mem_re),    32'(e.m != 0 && !e.we));
         chk("mem_addr",  32'(bus.mem_addr),  32'(e.addr));
         chk("mem_be",    32'(bus.mem_be),    32'(e.be));
         chk("mem_wdata", bus.mem_wdata,      e.wdata);
         if (prev_valid) begin
            chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(prev.m == 1 && !prev.we));
            chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(prev.m == 2 && !prev.we));
            if (prev.m == 1 && !prev.we) chk("cpu_rdata", bus.cpu_rdata, memf(prev.addr));
            if (prev.m == 2 && !prev.we) chk("dma_rdata", bus.dma_rdata, memf(prev.addr));
         end
         $display("TXN t=%0t owner=%0d we=%0b addr=%05h stall=%0b gnt=%0b rv=%0b/%0b",
                  $time, e.m, e.we, e.addr, bus.cpu_stall, bus.dma_gnt,
                  bus.cpu_rvalid, bus.dma_rvalid);
         prev       = e;
         prev_valid = 1'b1;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                        input logic dreq, input logic dwe, input logic dlast,
                        input logic [AW-1:0] daddr);
      bus.cpu_req   = creq;
      bus.cpu_we    = cwe;
      bus.cpu_addr  = caddr;
      bus.cpu_be    = caddr[4];
      bus.cpu_wdata = {12'hC00, caddr};
      bus.dma_req   = dreq;
      bus.dma_we    = dwe;
      bus.dma_last  = dlast;
      bus.dma_addr  = daddr;
      bus.dma_wdata = {12'hD00, daddr};
   endtask

   // One clock cycle of stimulus with its hand-derived expected owner and stall.
   task automatic cyc(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                      input logic dreq, input logic dwe, input logic dlast,
                      input logic [AW-1:0] daddr, input int m, input logic stall);
      exp_t e;
      drive(creq, cwe, caddr, dreq, dwe, dlast, daddr);
      e.m     = m;
      e.stall = stall;
      e.we    = (m == 1) ? cwe : ((m == 2) ? dwe : 1'b0);
      e.be    = (m == 1) ? caddr[4] : (m == 2);
      e.addr  = (m == 1) ? caddr : ((m == 2) ? daddr : '0);
      e.wdata = (m == 1) ? {12'hC00, caddr} : ((m == 2) ? {12'hD00, daddr} : '0);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with both masters requesting.
      drive(1'b1, 1'b1, 20'h00010, 1'b1, 1'b1, 1'b0, 20'h00100);
      #1;
      chk("rst_cpu_stall", 32'(bus.cpu_stall), 0);
      chk("rst_dma_gnt",   32'(bus.dma_gnt),   0);
      chk("rst_mem_we",    32'(bus.mem_we),    0);
      chk("rst_mem_re",    32'(bus.mem_re),    0);
      repeat (2) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      #1;
      chk("rst_state", 32'(dut.state_q), 0);
      chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
      @(posedge clk);
      #1;

      // 1: CPU only, read then write, no stall.
      cyc(1'b1, 1'b0, 20'h00010, 1'b0, 1'b0, 1'b0, '0, 1, 1'b0);
      cyc(1'b1, 1'b1, 20'h00004, 1'b0, 1'b0, 1'b0, '0, 1, 1'b0);
      idle();

      // 2: both request; CPU wins 8 cycles, DMA preempts in the 9th.
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 1'b0, 20'h00020 + 20'(i), 1'b1, 1'b1, 1'b1, 20'h00200, 1, 1'b0);
      cyc(1'b1, 1'b0, 20'h00028, 1'b1, 1'b1, 1'b1, 20'h00200, 2, 1'b1);
      cyc(1'b1, 1'b0, 20'h00030, 1'b0, 1'b0, 1'b0, '0, 1, 1'b0);
      idle();
`ifdef DMEM_ARB_STATS_EN
      chk("stats_stall", 32'(cpu_stall_cycles), 1);
      chk("stats_beats", 32'(dma_beats), 1);
`endif

      // 3: 20-beat DMA read burst, CPU joins at beat 3; cap after 16 beats.
      for (int b = 1; b <= 16; b++)
         cyc(b >= 3, 1'b0, 20'h00080, 1'b1, 1'b0, 1'b0, 20'h00300 + 20'(b), 2, b >= 3);
      cyc(1'b1, 1'b0, 20'h00080, 1'b1, 1'b0, 1'b0, 20'h00311, 1, 1'b0);
      cyc(1'b1, 1'b0, 20'h00084, 1'b1, 1'b0, 1'b0, 20'h00311, 1, 1'b0);
      for (int b = 17; b <= 20; b++)
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, b == 20, 20'h00300 + 20'(b), 2, 1'b0);
      idle();

      // 4: 4-beat DMA write burst ending on dma_last.
      for (int b = 1; b <= 4; b++)
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, b == 4, 20'h00400 + 20'(b), 2, 1'b0);
      chk("s4_state", 32'(dut.state_q), 0);
      chk("s4_wait",  32'(dut.wait_q), 0);
      chk("s4_burst", 32'(dut.burst_q), 0);
      idle();

      // 5: reset asserted during beat 5 of a write burst.
      for (int b = 1; b <= 4; b++)
         cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 20'h00500 + 20'(b), 2, 1'b0);
      drive(1'b1, 1'b0, 20'h00090, 1'b1, 1'b1, 1'b0, 20'h00505);
      #1;
      chk("s5_gnt_before", 32'(bus.dma_gnt), 1);
      chk("s5_stall_before", 32'(bus.cpu_stall), 1);
      #1;
      rst = 1'b0;
      #1;
      chk("s5_dma_gnt", 32'(bus.dma_gnt), 0);
      chk("s5_mem_we",  32'(bus.mem_we), 0);
      chk("s5_mem_re",  32'(bus.mem_re), 0);
      chk("s5_stall",   32'(bus.cpu_stall), 0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      #1;
      chk("s5_state", 32'(dut.state_q), 0);
      chk("s5_wait",  32'(dut.wait_q), 0);
      chk("s5_burst", 32'(dut.burst_q), 0);
      chk("s5_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
      chk("s5_dma_rvalid", 32'(bus.dma_rvalid), 0);
`ifdef DMEM_ARB_STATS_EN
      chk("s5_stats_stall", 32'(cpu_stall_cycles), 0);
      chk("s5_stats_beats", 32'(dma_beats), 0);
`endif
      @(posedge clk);
      #1;

`ifdef DMEM_ARB_STATS_EN
      // 6: beat counter saturates rather than wrapping.
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 20'h00600);
      repeat (65540) @(posedge clk);
      #1;
      chk("stats_beats_sat", 32'(dma_beats), 32'h0000FFFF);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
`endif

      // Normal operation after reset.
      cyc(1'b1, 1'b0, 20'h00010, 1'b0, 1'b0, 1'b0, '0, 1, 1'b0);
      idle();
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
